// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction fetch queue (ifq_multi_issue).
package ifq_pkg;

    localparam int unsigned INST_W     = 32;
    localparam int unsigned LINE_INSTS = 4;

    typedef logic [LINE_INSTS-1:0][INST_W-1:0] line_t;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } fetch_state_e;

    // Clears the in-line byte offset; insts is the line size in words (power of 2).
    function automatic logic [INST_W-1:0] line_align(input logic [INST_W-1:0] pc,
                                                     input int unsigned       insts);
        logic [INST_W-1:0] sz;
        sz = INST_W'(insts) << 2;
        return pc & ~(sz - INST_W'(1));
    endfunction

endpackage

// File: rtl/ifq_line_buf.sv
// Circular store of fetched lines with base PCs; head and head+1 readable for spanning dispatch.
module ifq_line_buf #(
    parameter  int unsigned INST_W     = 32,
    parameter  int unsigned LINE_INSTS = 4,
    parameter  int unsigned DEPTH      = 4,
    localparam int unsigned LW         = LINE_INSTS * INST_W,
    localparam int unsigned PTR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [LW-1:0]     wr_line,
    input  logic [INST_W-1:0] wr_pc,
    input  logic              pop,
    output logic [LW-1:0]     rd0_line,
    output logic [INST_W-1:0] rd0_pc,
    output logic [LW-1:0]     rd1_line,
    output logic [INST_W-1:0] rd1_pc,
    output logic [PTR_W:0]    count
);

    logic [LW-1:0]     line_mem [DEPTH];
    logic [INST_W-1:0] pc_mem   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_nx;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr_en) tail_d = tail_q + 1'b1;
            if (pop)   head_d = head_q + 1'b1;
            count_d = count_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            line_mem[tail_q] <= wr_line;
            pc_mem[tail_q]   <= wr_pc;
        end
    end

    assign head_nx  = head_q + 1'b1;
    assign rd0_line = line_mem[head_q];
    assign rd0_pc   = pc_mem[head_q];
    assign rd1_line = line_mem[head_nx];
    assign rd1_pc   = pc_mem[head_nx];
    assign count    = count_q;

endmodule

// File: rtl/ifq_multi_issue.sv
// Instruction fetch queue: line fetch FSM, redirect handling and multi-slot dispatch.
// Optional IFQ_BYPASS_EN: cache line feeds dispatch combinationally when the queue is empty.
module ifq_multi_issue #(
    parameter  int unsigned       INST_W     = ifq_pkg::INST_W,
    parameter  int unsigned       LINE_INSTS = ifq_pkg::LINE_INSTS,
    parameter  int unsigned       DEPTH      = 4,
    parameter  int unsigned       DISP_W     = 2,
    parameter  logic [INST_W-1:0] RESET_PC   = '0,
    localparam int unsigned       CNT_W      = $clog2(DISP_W + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [INST_W-1:0]            pc_in,
    output logic                         cache_rd_en,
    output logic                         cache_abort,
    input  logic [LINE_INSTS*INST_W-1:0] dout,
    input  logic                         dout_valid,
    output logic [DISP_W*INST_W-1:0]     pc_out,
    output logic [DISP_W*INST_W-1:0]     inst,
    output logic [DISP_W-1:0]            inst_valid,
    output logic                         empty,
    input  logic [CNT_W-1:0]             inst_rd_cnt,
    input  logic [INST_W-1:0]            jmp_branch_address,
    input  logic                         jmp_branch_valid
);
    import ifq_pkg::*;

    localparam int unsigned OFF_W = $clog2(LINE_INSTS);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned AW    = $clog2(2 * LINE_INSTS + 1);
    localparam int unsigned LW    = LINE_INSTS * INST_W;

    fetch_state_e      state_q, state_d;
    logic [INST_W-1:0] pc_in_q, pc_in_d;
    logic [OFF_W-1:0]  off_q, off_d;

    logic [PTR_W:0]    count, count_after;
    logic [LW-1:0]     rd0_line, rd1_line, src0_line;
    logic [INST_W-1:0] rd0_pc, rd1_pc, src0_pc;
    logic              accept, bypass, has0, has1, line_done, wr_en, pop;
    logic [AW-1:0]     rem0, avail, n_vis, rd_n, off_sum, w;

    always_comb begin
        accept = (state_q == S_REQ) && dout_valid && !jmp_branch_valid;
`ifdef IFQ_BYPASS_EN
        bypass = accept && (count == '0);
`else
        bypass = 1'b0;
`endif
        src0_line = bypass ? dout    : rd0_line;
        src0_pc   = bypass ? pc_in_q : rd0_pc;
        has0      = bypass || (count != '0);
        has1      = !bypass && (count > (PTR_W+1)'(1));
        rem0      = has0 ? (AW'(LINE_INSTS) - AW'(off_q)) : '0;
        avail     = rem0 + (has1 ? AW'(LINE_INSTS) : '0);
        n_vis     = (avail > AW'(DISP_W)) ? AW'(DISP_W) : avail;
        if (jmp_branch_valid)
            rd_n = '0;
        else
            rd_n = (AW'(inst_rd_cnt) < n_vis) ? AW'(inst_rd_cnt) : n_vis;
        off_sum   = AW'(off_q) + rd_n;
        line_done = has0 && (off_sum >= AW'(LINE_INSTS));
        // A bypassed line that is fully consumed never enters the queue.
        wr_en       = accept && !(bypass && line_done);
        pop         = line_done && !bypass && !jmp_branch_valid;
        count_after = count + (PTR_W+1)'(wr_en) - (PTR_W+1)'(pop);
        empty       = (n_vis == '0);
    end

    always_comb begin
        inst_valid = '0;
        pc_out     = '0;
        inst       = '0;
        w          = '0;
        for (int unsigned k = 0; k < DISP_W; k++) begin
            w = AW'(off_q) + AW'(k);
            if (AW'(k) < n_vis) begin
                inst_valid[k] = 1'b1;
                if (w < AW'(LINE_INSTS)) begin
                    inst[k*INST_W +: INST_W]   = src0_line[w*INST_W +: INST_W];
                    pc_out[k*INST_W +: INST_W] = src0_pc + (INST_W'(w) << 2);
                end else begin
                    inst[k*INST_W +: INST_W]   = rd1_line[(w - AW'(LINE_INSTS))*INST_W +: INST_W];
                    pc_out[k*INST_W +: INST_W] = rd1_pc + (INST_W'(w - AW'(LINE_INSTS)) << 2);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_in_d     = pc_in_q;
        off_d       = off_q;
        cache_abort = 1'b0;
        if (jmp_branch_valid) begin
            state_d     = S_REQ;
            pc_in_d     = line_align(jmp_branch_address, LINE_INSTS);
            off_d       = jmp_branch_address[OFF_W+1:2];
            cache_abort = (state_q == S_REQ) && !dout_valid;
        end else begin
            off_d = line_done ? OFF_W'(off_sum - AW'(LINE_INSTS)) : OFF_W'(off_sum);
            case (state_q)
                S_IDLE: if (count_after < (PTR_W+1)'(DEPTH)) state_d = S_REQ;
                S_REQ: begin
                    if (accept) begin
                        pc_in_d = pc_in_q + INST_W'(LINE_INSTS * 4);
                        if (count_after >= (PTR_W+1)'(DEPTH)) state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_in_q <= RESET_PC;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_in_q <= pc_in_d;
            off_q   <= off_d;
        end
    end

    assign pc_in       = pc_in_q;
    assign cache_rd_en = (state_q == S_REQ);

    ifq_line_buf #(
        .INST_W     (INST_W),
        .LINE_INSTS (LINE_INSTS),
        .DEPTH      (DEPTH)
    ) u_line_buf (
        .clk      (clk),
        .rst_n    (rst),
        .flush    (jmp_branch_valid),
        .wr_en    (wr_en),
        .wr_line  (dout),
        .wr_pc    (pc_in_q),
        .pop      (pop),
        .rd0_line (rd0_line),
        .rd0_pc   (rd0_pc),
        .rd1_line (rd1_line),
        .rd1_pc   (rd1_pc),
        .count    (count)
    );

endmodule

// File: tb/tb_ifq_multi_issue.sv
// Directed self-checking bench for ifq_multi_issue (default build; IFQ_BYPASS_EN variant checked where noted).
module tb_ifq_multi_issue;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pc_in;
    logic         cache_rd_en;
    logic         cache_abort;
    logic [127:0] dout;
    logic         dout_valid;
    logic [63:0]  pc_out;
    logic [63:0]  inst;
    logic [1:0]   inst_valid;
    logic         empty;
    logic [1:0]   inst_rd_cnt;
    logic [31:0]  jmp_branch_address;
    logic         jmp_branch_valid;

    int unsigned checks = 0;
    int unsigned errors = 0;

    ifq_multi_issue #(
        .INST_W     (32),
        .LINE_INSTS (4),
        .DEPTH      (4),
        .DISP_W     (2),
        .RESET_PC   (32'h0)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .pc_in              (pc_in),
        .cache_rd_en        (cache_rd_en),
        .cache_abort        (cache_abort),
        .dout               (dout),
        .dout_valid         (dout_valid),
        .pc_out             (pc_out),
        .inst               (inst),
        .inst_valid         (inst_valid),
        .empty              (empty),
        .inst_rd_cnt        (inst_rd_cnt),
        .jmp_branch_address (jmp_branch_address),
        .jmp_branch_valid   (jmp_branch_valid)
    );

    always #5 clk = ~clk;

    // Instruction word stored at address p is ~p.
    function automatic logic [127:0] mk_line(input logic [31:0] base);
        logic [127:0] l;
        for (int unsigned i = 0; i < 4; i++) l[i*32 +: 32] = ~(base + 32'(i * 4));
        return l;
    endfunction

    function automatic logic [63:0] pair(input logic [31:0] s0, input logic [31:0] s1);
        return {s1, s0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request cycle, then the cache answers one cycle later.
    task automatic fetch_line(input logic [31:0] a);
        check("req_en", 64'(cache_rd_en), 64'd1);
        check("req_pc", 64'(pc_in), 64'(a));
        tick();
        dout_valid = 1'b1;
        dout       = mk_line(a);
        tick();
        dout_valid = 1'b0;
    endtask

    initial begin
        rst                = 1'b0;
        dout               = '0;
        dout_valid         = 1'b0;
        inst_rd_cnt        = '0;
        jmp_branch_address = '0;
        jmp_branch_valid   = 1'b0;

        // reset values
        tick();
        tick();
        check("rst_pc_in", 64'(pc_in), 64'h0);
        check("rst_rd_en", 64'(cache_rd_en), 64'd0);
        check("rst_abort", 64'(cache_abort), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_pc_out", pc_out, 64'h0);
        check("rst_inst", inst, 64'h0);
        rst = 1'b1;
        check("idle_rd_en", 64'(cache_rd_en), 64'd0);
        tick();

        // 1: fill the queue with four lines
        for (int unsigned i = 0; i < 4; i++) fetch_line(32'(i * 16));
        check("full_rd_en", 64'(cache_rd_en), 64'd0);
        check("full_empty", 64'(empty), 64'd0);
        check("full_valid", 64'(inst_valid), 64'd3);
        check("full_pc_out", pc_out, pair(32'h0, 32'h4));
        check("full_inst", inst, pair(~32'h0, ~32'h4));
        tick();
        check("full_hold_rd_en", 64'(cache_rd_en), 64'd0);

        // 2: drain two per cycle
        inst_rd_cnt = 2'd2;
        #1;
        check("drain_pc0", pc_out, pair(32'h0, 32'h4));
        tick();
        check("drain_pc1", pc_out, pair(32'h8, 32'hC));
        check("drain_no_req", 64'(cache_rd_en), 64'd0);
        tick();
        check("resume_rd_en", 64'(cache_rd_en), 64'd1);
        check("resume_pc_in", 64'(pc_in), 64'h40);
        check("drain_pc2", pc_out, pair(32'h10, 32'h14));
        tick();
        check("drain_pc3", pc_out, pair(32'h18, 32'h1C));
        tick();
        check("drain_pc4", pc_out, pair(32'h20, 32'h24));
        inst_rd_cnt = 2'd0;

        // reset while the 0x40 fetch is outstanding; a late response must be dropped
        rst        = 1'b0;
        dout_valid = 1'b1;
        dout       = mk_line(32'h40);
        #1;
        check("mid_rst_pc_in", 64'(pc_in), 64'h0);
        check("mid_rst_empty", 64'(empty), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        dout_valid = 1'b0;
        #1;
        check("post_rst_empty", 64'(empty), 64'd1);

        // 3: redirect to 0x1008 while 0x20 is pending
        fetch_line(32'h0);
        fetch_line(32'h10);
        check("pend_pc", 64'(pc_in), 64'h20);
        jmp_branch_valid   = 1'b1;
        jmp_branch_address = 32'h1008;
        #1;
        check("abort_pulse", 64'(cache_abort), 64'd1);
        tick();
        jmp_branch_valid = 1'b0;
        #1;
        check("abort_once", 64'(cache_abort), 64'd0);
        check("redir_pc_in", 64'(pc_in), 64'h1000);
        check("redir_rd_en", 64'(cache_rd_en), 64'd1);
        check("redir_flush", 64'(empty), 64'd1);
        tick();
        dout_valid = 1'b1;
        dout       = mk_line(32'h1000);
        #1;
`ifdef IFQ_BYPASS_EN
        check("redir_byp_valid", 64'(inst_valid), 64'd3);
        check("redir_byp_pc", pc_out, pair(32'h1008, 32'h100C));
`else
        check("redir_same_cyc", 64'(inst_valid), 64'd0);
`endif
        tick();
        dout_valid = 1'b0;
        #1;
        check("redir_valid", 64'(inst_valid), 64'd3);
        check("redir_pc_out", pc_out, pair(32'h1008, 32'h100C));
        check("redir_inst", inst, pair(~32'h1008, ~32'h100C));
        inst_rd_cnt = 2'd2;
        tick();
        inst_rd_cnt = 2'd0;
        #1;
        check("redir_drained", 64'(empty), 64'd1);
        check("redir_next_pc", 64'(pc_in), 64'h1010);

        // 4: redirect, pop and dout_valid together
        dout_valid = 1'b1;
        dout       = mk_line(32'h1010);
        tick();
        inst_rd_cnt        = 2'd2;
        dout               = mk_line(32'h1020);
        jmp_branch_valid   = 1'b1;
        jmp_branch_address = 32'h2004;
        #1;
        check("coll_no_abort", 64'(cache_abort), 64'd0);
        tick();
        inst_rd_cnt      = 2'd0;
        dout_valid       = 1'b0;
        jmp_branch_valid = 1'b0;
        #1;
        check("coll_empty", 64'(empty), 64'd1);
        check("coll_pc_in", 64'(pc_in), 64'h2000);
        tick();
        dout_valid = 1'b1;
        dout       = mk_line(32'h2000);
        tick();
        dout_valid = 1'b0;
        #1;
        check("coll_target", pc_out, pair(32'h2004, 32'h2008));

        // 5: single instruction at 0x3C, over-asked pop
        jmp_branch_valid   = 1'b1;
        jmp_branch_address = 32'h3C;
        #1;
        check("abort2", 64'(cache_abort), 64'd1);
        tick();
        jmp_branch_valid = 1'b0;
        #1;
        check("one_pc_in", 64'(pc_in), 64'h30);
        tick();
        dout_valid = 1'b1;
        dout       = mk_line(32'h30);
        tick();
        dout_valid = 1'b0;
        #1;
        check("one_valid", 64'(inst_valid), 64'd1);
        check("one_pc_out", pc_out, pair(32'h3C, 32'h0));
        check("one_inst", inst, pair(~32'h3C, 32'h0));
        inst_rd_cnt = 2'd2;
        tick();
        check("one_empty", 64'(empty), 64'd1);
        check("one_gone", 64'(inst_valid), 64'd0);
        tick();
        inst_rd_cnt = 2'd0;
        #1;
        check("uflow_empty", 64'(empty), 64'd1);
        check("uflow_pc_in", 64'(pc_in), 64'h40);
        check("uflow_rd_en", 64'(cache_rd_en), 64'd1);

        // 6: line arriving into an empty queue
        dout_valid = 1'b1;
        dout       = mk_line(32'h40);
        #1;
`ifdef IFQ_BYPASS_EN
        check("byp_valid", 64'(inst_valid), 64'd3);
        check("byp_pc_out", pc_out, pair(32'h40, 32'h44));
`else
        check("nobyp_valid", 64'(inst_valid), 64'd0);
        check("nobyp_empty", 64'(empty), 64'd1);
`endif
        tick();
        dout_valid = 1'b0;
        #1;
        check("late_valid", 64'(inst_valid), 64'd3);
        check("late_pc_out", pc_out, pair(32'h40, 32'h44));
        check("late_inst", inst, pair(~32'h40, ~32'h44));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
